// File: rtl/alu_rr_scheduler.sv
// alu_rr_scheduler: round-robin sharing of one registered ALU between NREQ requesters
module alu_rr_scheduler #(
  parameter int NREQ = 4,
  parameter int DW = 4,
  parameter int RW = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*DW-1:0] req_a,
  input  logic [NREQ*DW-1:0] req_b,
  input  logic [NREQ*3-1:0] req_op,
  output logic              alu_reset,
  output logic [DW-1:0]     alu_a,
  output logic [DW-1:0]     alu_b,
  output logic [2:0]        alu_op,
  input  logic [RW-1:0]     alu_c,
  output logic [NREQ-1:0]   resp_valid,
  input  logic [NREQ-1:0]   resp_ready,
  output logic [RW-1:0]     resp_data,
  output logic              resp_err,
  output logic              busy
);
  localparam int PW = NREQ > 1 ? $clog2(NREQ) : 1;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t state, state_nx;
  logic [PW-1:0] rr_ptr, owner, gnt_idx, cand;
  logic gnt_any, err_q, accept;
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = PW'((int'(rr_ptr) + k) % NREQ);
      if (!gnt_any && req_valid[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
  end
  // Ready is gated by reset so requesters never see an accept while held in reset
  assign accept = reset_n && state == IDLE && gnt_any;
  assign req_ready = accept ? NREQ'(1) << gnt_idx : '0;
  assign alu_reset = ~reset_n;
  assign busy = state != IDLE;
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  state_nx = gnt_any ? ISSUE : IDLE;
      ISSUE: state_nx = WAIT;
      WAIT:  state_nx = RESP;
      RESP:  state_nx = resp_ready[owner] ? IDLE : RESP;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      rr_ptr <= PW'(NREQ - 1);
      owner <= '0;
      alu_a <= '0;
      alu_b <= '0;
      alu_op <= '0;
      err_q <= 1'b0;
      resp_valid <= '0;
      resp_data <= '0;
      resp_err <= 1'b0;
    end else begin
      if (accept) begin
        alu_a <= req_a[gnt_idx*DW +: DW];
        alu_b <= req_b[gnt_idx*DW +: DW];
        alu_op <= req_op[gnt_idx*3 +: 3];
        owner <= gnt_idx;
        rr_ptr <= gnt_idx;
        err_q <= req_op[gnt_idx*3 +: 3] == 3'd3 && req_b[gnt_idx*DW +: DW] == '0;
      end
      if (state == WAIT) begin
        resp_data <= err_q ? '0 : alu_c;
        resp_err <= err_q;
        resp_valid <= NREQ'(1) << owner;
      end
      if (state == RESP && resp_ready[owner]) resp_valid <= '0;
    end
endmodule

// File: tb/tb_alu_rr_scheduler.sv
// tb_alu_rr_scheduler: randomized transaction-level check of the ALU scheduler
module tb_alu_rr_scheduler;
  localparam int NREQ = 4, DW = 4, RW = 8;
  logic clk, reset_n, alu_reset, resp_err, busy;
  logic [NREQ-1:0] req_valid, req_ready, resp_valid, resp_ready;
  logic [NREQ*DW-1:0] req_a, req_b;
  logic [NREQ*3-1:0] req_op;
  logic [DW-1:0] alu_a, alu_b;
  logic [2:0] alu_op;
  logic [RW-1:0] alu_c, resp_data;
  int n_chk = 0, n_err = 0;
  bit pend[NREQ];
  logic [3:0] pa[NREQ], pb[NREQ];
  logic [2:0] pop[NREQ];
  int last = NREQ - 1;
  int got_w;
  logic [7:0] got_data;
  logic got_err;

  alu_rr_scheduler #(.NREQ(NREQ), .DW(DW), .RW(RW)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op), .alu_reset(alu_reset),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_c(alu_c),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_err(resp_err), .busy(busy));

  initial clk = 0;
  always #5 clk = ~clk;

  function automatic logic [7:0] alu_f(logic [3:0] a, logic [3:0] b, logic [2:0] op);
    case (op)
      3'd0: return 8'(a) + 8'(b);
      3'd1: return 8'(a) - 8'(b);
      3'd2: return 8'(a) * 8'(b);
      3'd3: return b == 0 ? 8'hff : 8'(a / b);
      3'd4: return {4'h0, a & b};
      3'd5: return {4'h0, a | b};
      3'd6: return {4'h0, a ^ b};
      default: return {4'h0, ~a};
    endcase
  endfunction

  // Stand-in for the shared ALU: one registered stage, active-high reset
  always_ff @(posedge clk or posedge alu_reset)
    if (alu_reset) alu_c <= '0;
    else alu_c <= alu_f(alu_a, alu_b, alu_op);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i] = pend[i];
      req_a[i*DW +: DW] = pa[i];
      req_b[i*DW +: DW] = pb[i];
      req_op[i*3 +: 3] = pop[i];
    end
  endtask

  task automatic set_req(input int i, input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
    pend[i] = 1;
    pa[i] = a;
    pb[i] = b;
    pop[i] = op;
  endtask

  task automatic rand_req(input int i);
    if ($urandom_range(0, 7) == 0) set_req(i, 4'($urandom), 4'h0, 3'd3);
    else set_req(i, 4'($urandom), 4'($urandom), 3'($urandom));
  endtask

  // One full accept/response transaction; caller is just past a negedge with DUT idle
  task automatic do_op(input bit add_rand, input int hold);
    bit any;
    logic [NREQ-1:0] one_w;
    logic exp_e;
    logic [7:0] exp_d;
    if (add_rand)
      for (int i = 0; i < NREQ; i++) if (!pend[i] && $urandom_range(0, 1) == 1) rand_req(i);
    any = 0;
    for (int i = 0; i < NREQ; i++) any |= pend[i];
    if (!any) rand_req($urandom_range(0, NREQ - 1));
    drive();
    #1;
    got_w = -1;
    for (int k = 1; k <= NREQ; k++) if (got_w < 0 && pend[(last + k) % NREQ]) got_w = (last + k) % NREQ;
    one_w = NREQ'(1) << got_w;
    check("req_ready", 32'(req_ready), 32'(one_w));
    check("busy_idle", 32'(busy), 0);
    check("alu_reset_run", 32'(alu_reset), 0);
    exp_e = pop[got_w] == 3'd3 && pb[got_w] == 0;
    exp_d = exp_e ? 8'h00 : alu_f(pa[got_w], pb[got_w], pop[got_w]);
    @(posedge clk);
    @(negedge clk);
    pend[got_w] = 0;
    last = got_w;
    drive();
    #1;
    check("alu_a", 32'(alu_a), 32'(pa[got_w]));
    check("alu_b", 32'(alu_b), 32'(pb[got_w]));
    check("alu_op", 32'(alu_op), 32'(pop[got_w]));
    check("busy_issue", 32'(busy), 1);
    check("ready_issue", 32'(req_ready), 0);
    check("resp_early1", 32'(resp_valid), 0);
    @(negedge clk);
    check("resp_early2", 32'(resp_valid), 0);
    @(negedge clk);
    check("resp_valid", 32'(resp_valid), 32'(one_w));
    check("resp_data", 32'(resp_data), 32'(exp_d));
    check("resp_err", 32'(resp_err), 32'(exp_e));
    got_data = resp_data;
    got_err = resp_err;
    repeat (hold) begin
      resp_ready = NREQ'($urandom) & ~one_w;
      @(negedge clk);
      check("hold_valid", 32'(resp_valid), 32'(one_w));
      check("hold_data", 32'(resp_data), 32'(exp_d));
      check("hold_err", 32'(resp_err), 32'(exp_e));
      check("hold_ready", 32'(req_ready), 0);
      check("hold_busy", 32'(busy), 1);
    end
    resp_ready = NREQ'($urandom) | one_w;
    @(negedge clk);
    resp_ready = '0;
    check("released_valid", 32'(resp_valid), 0);
    check("released_busy", 32'(busy), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    reset_n = 0;
    resp_ready = '0;
    for (int i = 0; i < NREQ; i++) set_req(i, 4'hf, 4'hf, 3'd5);
    drive();
    repeat (2) @(negedge clk);
    #1;
    check("rst_req_ready", 32'(req_ready), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_resp_valid", 32'(resp_valid), 0);
    check("rst_resp_data", 32'(resp_data), 0);
    check("rst_resp_err", 32'(resp_err), 0);
    check("rst_alu_reset", 32'(alu_reset), 1);
    check("rst_alu_a", 32'(alu_a), 0);
    check("rst_alu_op", 32'(alu_op), 0);
    for (int i = 0; i < NREQ; i++) pend[i] = 0;
    drive();
    @(negedge clk);
    reset_n = 1;
    for (int i = 0; i < NREQ; i++) set_req(i, 4'(i + 1), 4'd2, 3'd2);
    for (int k = 0; k < NREQ; k++) begin
      do_op(0, 0);
      check("rr_order", 32'(got_w), 32'(k));
      check("rr_data", 32'(got_data), 32'(2 * (k + 1)));
    end
    for (int i = 0; i < NREQ; i++) set_req(i, 4'(i + 1), 4'd2, 3'd2);
    do_op(0, 0);
    check("rr_wrap", 32'(got_w), 0);
    repeat (NREQ - 1) do_op(0, 1);
    set_req(0, 4'd9, 4'd6, 3'd0);
    do_op(0, 5);
    check("single_data", 32'(got_data), 15);
    check("single_err", 32'(got_err), 0);
    set_req(2, 4'd7, 4'd0, 3'd3);
    do_op(0, 0);
    check("div0_owner", 32'(got_w), 2);
    check("div0_data", 32'(got_data), 0);
    check("div0_err", 32'(got_err), 1);
    set_req(2, 4'd7, 4'd2, 3'd3);
    do_op(0, 0);
    check("div_data", 32'(got_data), 3);
    check("div_err", 32'(got_err), 0);
    repeat (120) do_op(1, $urandom_range(0, 3));
    for (int i = 0; i < NREQ; i++) pend[i] = 0;
    set_req(1, 4'd3, 4'd4, 3'd0);
    drive();
    for (int c = 0; c < 8 && resp_valid == 0; c++) @(negedge clk);
    check("midresp_reached", 32'(resp_valid), 32'(4'b0010));
    #2;
    reset_n = 0;
    #1;
    check("midrst_resp_valid", 32'(resp_valid), 0);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_alu_reset", 32'(alu_reset), 1);
    check("midrst_req_ready", 32'(req_ready), 0);
    check("midrst_alu_a", 32'(alu_a), 0);
    check("midrst_resp_data", 32'(resp_data), 0);
    for (int i = 0; i < NREQ; i++) pend[i] = 0;
    drive();
    @(negedge clk);
    reset_n = 1;
    last = NREQ - 1;
    repeat (20) do_op(1, $urandom_range(0, 3));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
